game_seq_ctrl: RTL and testbench

Sequencing and arbitration controller in front of the score tracker. Owns the game-state FSM (IDLE, PLAY, OVER) and samples three collision detectors once per game step. It issues at most one single-cycle `good_coll`/`bad_coll` pulse per step to the score datapath. It also gates snake movement and selects current- versus high-score display.

---
 rtl/game_pkg.sv | 26 ++
 rtl/btn_sync_edge.sv | 31 +++
 rtl/game_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_game_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the snake game control slice.
package game_pkg;

  // Width of the score bus coming back from the score tracker.
  localparam int SCORE_W = 7;

  // Default winning score; the tracker must use the same limit.
  localparam int MAX_SCORE_DEF = 50;

  // Width of the OVER dwell counter (OVER_TICKS is 1..255).
  localparam int CNT_W = 8;

  // Game state; encoding is visible on the state output.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  // Unsigned score comparison against the winning limit.
  function automatic logic score_reached(input logic [SCORE_W-1:0] score,
                                         input logic [SCORE_W-1:0] limit);
    return (score >= limit);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous push-button followed by a
// rising-edge detector. rise is high for one cycle per press, however long
// the button is held. rise is decoded from registers only, so it is glitch
// free for downstream logic.
module btn_sync_edge (
  input  logic clk,
  input  logic nRst,
  input  logic btn,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Metastability chain plus one history flop for edge detection.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/game_seq_ctrl.sv
// Game sequencing and collision arbitration in front of the score tracker.
//
// Pulse semantics toward the tracker: good_coll, bad_coll and clr_board are
// registered single-cycle strobes with no back-pressure. The tracker must
// accept a strobe in the cycle it is high. At most one of good_coll or
// bad_coll fires per step_tick, and never both at once.
module game_seq_ctrl
  import game_pkg::*;
#(
  parameter int MAX_SCORE  = MAX_SCORE_DEF,
  parameter int OVER_TICKS = 8
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       start_btn,
  input  logic       step_tick,
  input  logic       apple_hit,
  input  logic       wall_hit,
  input  logic       self_hit,
  input  logic [6:0] score,
  output logic       good_coll,
  output logic       bad_coll,
  output logic       run_en,
  output logic       clr_board,
  output logic       show_high,
  output logic       win,
  output logic [1:0] state
);

  localparam logic [SCORE_W-1:0] MAX_SCORE_L  = SCORE_W'(MAX_SCORE);
  localparam logic [CNT_W-1:0]   OVER_TICKS_L = CNT_W'(OVER_TICKS);

  // Synchronized start request: one strobe per press.
  logic start_rise;

  btn_sync_edge u_start_sync (
    .clk  (clk),
    .nRst (nRst),
    .btn  (start_btn),
    .rise (start_rise)
  );

  state_t           state_q, state_d;
  logic             good_q, good_d;
  logic             bad_q, bad_d;
  logic             clr_q, clr_d;
  logic             win_q, win_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  // State register plus all registered outputs and bookkeeping.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      good_q  <= 1'b0;
      bad_q   <= 1'b0;
      clr_q   <= 1'b0;
      win_q   <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      clr_q   <= clr_d;
      win_q   <= win_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, collision arbitration and OVER dwell counting.
  // In PLAY, a step tick is resolved in strict priority: a fatal hit beats
  // reaching the winning score, which beats eating an apple. The re-arm
  // flag makes a held apple_hit score only once until it is seen low.
  always_comb begin
    state_d = state_q;
    good_d  = 1'b0;
    bad_d   = 1'b0;
    clr_d   = 1'b0;
    win_d   = win_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d = PLAY;
          clr_d   = 1'b1;
          win_d   = 1'b0;
          armed_d = 1'b1;
          cnt_d   = '0;
        end
      end

      PLAY: begin
        if (step_tick) begin
          if (wall_hit || self_hit) begin
            bad_d   = 1'b1;
            state_d = OVER;
            win_d   = 1'b0;
            cnt_d   = '0;
          end else if (score_reached(score, MAX_SCORE_L)) begin
            // The tracker clears itself at the limit, so no strobe here.
            state_d = OVER;
            win_d   = 1'b1;
            cnt_d   = '0;
          end else if (apple_hit) begin
            if (armed_q) begin
              good_d  = 1'b1;
              armed_d = 1'b0;
            end
          end else begin
            armed_d = 1'b1;
          end
        end
      end

      OVER: begin
        if (step_tick) begin
          if (cnt_inc == OVER_TICKS_L) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign good_coll = good_q;
  assign bad_coll  = bad_q;
  assign clr_board = clr_q;
  assign win       = win_q;
  assign run_en    = (state_q == PLAY);
  assign show_high = (state_q == OVER);
  assign state     = state_q;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Directed bench for game_seq_ctrl. Stimulus pushes the expected output
// tuple for each strobe it provokes; an independent monitor pops and
// compares whenever a strobe appears. Static state checks are made inline.
module tb_game_seq_ctrl;
  import game_pkg::*;

  localparam int W = 8;

  logic       clk;
  logic       nRst;
  logic       start_btn;
  logic       step_tick;
  logic       apple_hit;
  logic       wall_hit;
  logic       self_hit;
  logic [6:0] score;
  logic       good_coll;
  logic       bad_coll;
  logic       run_en;
  logic       clr_board;
  logic       show_high;
  logic       win;
  logic [1:0] state;

  int n_vec = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  game_seq_ctrl dut (
    .clk       (clk),
    .nRst      (nRst),
    .start_btn (start_btn),
    .step_tick (step_tick),
    .apple_hit (apple_hit),
    .wall_hit  (wall_hit),
    .self_hit  (self_hit),
    .score     (score),
    .good_coll (good_coll),
    .bad_coll  (bad_coll),
    .run_en    (run_en),
    .clr_board (clr_board),
    .show_high (show_high),
    .win       (win),
    .state     (state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  // Tuple layout: {clr, good, bad, state[1:0], win, run_en, show_high}
  function automatic logic [W-1:0] pk(input logic c, input logic g,
                                      input logic b, input logic [1:0] s,
                                      input logic w, input logic r,
                                      input logic h);
    return {c, g, b, s, w, r, h};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {clr_board, good_coll, bad_coll, state, win, run_en, show_high};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (good_coll || bad_coll || clr_board) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_strobe: got %0h expected none", dut_vec());
      end else begin
        check("strobe", 32'(dut_vec()), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic drained(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // One step tick with the given hit levels; returns after the strobe slot.
  task automatic tick(input logic a, input logic w, input logic s,
                      input logic [6:0] sc);
    @(posedge clk);
    #1;
    step_tick = 1'b1;
    apple_hit = a;
    wall_hit  = w;
    self_hit  = s;
    score     = sc;
    @(posedge clk);
    #1;
    step_tick = 1'b0;
    apple_hit = 1'b0;
    wall_hit  = 1'b0;
    self_hit  = 1'b0;
    settle();
  endtask

  // Press start and check the two-edge synchronizer latency.
  task automatic press_start();
    exp_q.push_back(pk(1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    start_btn = 1'b1;
    @(posedge clk);                // edge k: first sample
    @(negedge clk);
    check("start_k0_idle", 32'(state), 32'd0);
    @(posedge clk);                // edge k+1
    @(negedge clk);
    check("start_k1_idle", 32'(state), 32'd0);
    @(posedge clk);                // edge k+2
    @(negedge clk);
    check("start_k2_play", 32'(state), 32'd1);
    @(negedge clk);
    check("clr_one_cycle", 32'(clr_board), 32'd0);
    check("run_en_play", 32'(run_en), 32'd1);
    #1;
    start_btn = 1'b0;
    repeat (3) @(posedge clk);
    settle();
    drained("start_drained");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nRst      = 1'b0;
    start_btn = 1'b0;
    step_tick = 1'b0;
    apple_hit = 1'b0;
    wall_hit  = 1'b0;
    self_hit  = 1'b0;
    score     = 7'd0;
    repeat (3) @(posedge clk);
    settle();
    check("reset_outputs", 32'(dut_vec()), 32'd0);
    @(posedge clk);
    #1;
    nRst = 1'b1;
    repeat (2) @(posedge clk);

    // Start a game.
    press_start();

    // Hits without step_tick in PLAY are ignored.
    @(posedge clk);
    #1;
    apple_hit = 1'b1;
    wall_hit  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    apple_hit = 1'b0;
    wall_hit  = 1'b0;
    settle();
    check("no_tick_state", 32'(state), 32'd1);
    drained("no_tick_drained");

    // Held apple: 3 high ticks, 1 low, 1 high -> two good strobes.
    exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0));
    tick(1'b1, 1'b0, 1'b0, 7'd3);
    drained("apple_first");
    tick(1'b1, 1'b0, 1'b0, 7'd4);
    tick(1'b1, 1'b0, 1'b0, 7'd4);
    tick(1'b0, 1'b0, 1'b0, 7'd4);
    drained("apple_held");
    exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0));
    tick(1'b1, 1'b0, 1'b0, 7'd4);
    drained("apple_rearmed");

    // Apple and wall on one tick: bad strobe only, enter OVER.
    exp_q.push_back(pk(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1));
    tick(1'b1, 1'b1, 1'b0, 7'd5);
    drained("collide_drained");
    check("collide_show_high", 32'(show_high), 32'd1);

    // Start press during OVER is ignored.
    @(posedge clk);
    #1;
    start_btn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    start_btn = 1'b0;
    repeat (3) @(posedge clk);
    settle();
    check("over_start_ignored", 32'(state), 32'd2);

    // OVER dwell: 7 ticks stay, 8th returns to IDLE.
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 1'b0, 7'd5);
    check("over_after7", 32'(state), 32'd2);
    tick(1'b0, 1'b0, 1'b0, 7'd5);
    check("over_after8", 32'(dut_vec()), 32'(pk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0)));

    // Hits in IDLE are ignored.
    tick(1'b1, 1'b1, 1'b1, 7'd5);
    check("idle_hits_state", 32'(state), 32'd0);
    drained("idle_hits_drained");

    // Win: score at limit together with apple, no strobe.
    press_start();
    tick(1'b1, 1'b0, 1'b0, 7'd50);
    check("win_vec", 32'(dut_vec()), 32'(pk(1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1)));
    drained("win_no_strobe");
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0, 7'd0);
    check("win_idle_vec", 32'(dut_vec()), 32'(pk(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0)));

    // New game clears win; then reset mid-game just before a scoring edge.
    press_start();
    @(posedge clk);
    #1;
    step_tick = 1'b1;
    apple_hit = 1'b1;
    score     = 7'd7;
    #2;
    nRst = 1'b0;
    #1;
    check("async_reset_vec", 32'(dut_vec()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    step_tick = 1'b0;
    apple_hit = 1'b0;
    nRst      = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 7'd7);
    tick(1'b0, 1'b1, 1'b0, 7'd7);
    check("post_reset_idle", 32'(state), 32'd0);
    drained("post_reset_drained");

    // A start edge is required to play again.
    press_start();
    exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0));
    tick(1'b1, 1'b0, 1'b0, 7'd0);
    drained("final_drained");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
